// File: rtl/reg_dump_ctrl.sv
// Halts the CPU on a PC trigger and streams pc, instr and r0..r31 out.
// Define REG_DUMP_TIMEOUT_EN to also force a dump after MAX_CYCLES run cycles.
module reg_dump_ctrl #(
  parameter logic [31:0] TRIG_PC    = 32'h00000048,
  parameter int          MAX_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        cpu_halt,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [5:0]  dump_idx,
  output logic        dump_last,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    RUN,
    SEL,
    CAP,
    SEND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        trig;
  logic        lim;
  logic        hit;
  logic        acc;
  logic [31:0] instr_snap;

  assign trig = (pc == TRIG_PC);
  assign hit  = (state == RUN) && (trig || lim);
  assign acc  = (state == SEND) && dump_ready;

`ifdef REG_DUMP_TIMEOUT_EN
  localparam int CL = $clog2(MAX_CYCLES + 1);
  localparam int CW = (CL > 10) ? CL : 10;
  localparam logic [CW-1:0] LIM = CW'(MAX_CYCLES - 1);

  logic [CW-1:0] cyc_cnt;
  logic          to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (state == RUN && cyc_cnt != '1) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // the limit fires on the edge that closes the MAX_CYCLES-th run cycle
  assign lim = (state == RUN) && (cyc_cnt >= LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= 1'b0;
    end else if (lim) begin
      to_q <= 1'b1;
    end
  end

  assign timeout = to_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^MAX_CYCLES;
  assign lim        = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN: begin
        if (hit) state_nx = SEND;
      end
      SEL: state_nx = CAP;
      CAP: state_nx = SEND;
      SEND: begin
        if (dump_ready) begin
          if (dump_idx == 6'd0) begin
            state_nx = SEND;
          end else if (dump_idx == 6'd33) begin
            state_nx = DONE;
          end else begin
            state_nx = SEL;
          end
        end
      end
      DONE: state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    cpu_halt   = (state != RUN);
    dump_valid = (state == SEND);
    done       = (state == DONE);
  end

  // word 0 is the pc snapshot itself, so pc is loaded straight into dump_data
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_snap <= '0;
      dump_data  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
      reg_sel    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hit) begin
            instr_snap <= instr;
            dump_data  <= pc;
            dump_idx   <= '0;
            dump_last  <= 1'b0;
          end
        end
        SEL: begin
          reg_sel <= 5'(dump_idx - 6'd2);
        end
        CAP: begin
          dump_data <= (dump_idx == 6'd2) ? 32'h0 : reg_data;
          dump_last <= (dump_idx == 6'd33);
        end
        SEND: begin
          if (acc && dump_idx != 6'd33) begin
            dump_idx <= dump_idx + 6'd1;
            if (dump_idx == 6'd0) dump_data <= instr_snap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
